// File: rtl/dmem_wbuf_responder.sv
// Data-memory responder: posts CPU stores into an in-order write buffer drained to a
// ready-handshaked backing store; loads forward the youngest buffered match. Optional: WBUF_STATS_EN.
module dmem_wbuf_responder #(
   parameter int unsigned BUF_DEPTH = 4,
   parameter int unsigned AW        = 30
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         MemWrite,
   input  logic [31:0]                  ALUResult,
   input  logic [31:0]                  WriteData,
   output logic [31:0]                  ReadData,
   output logic [AW-1:0]                bs_raddr,
   input  logic [31:0]                  bs_rdata,
   output logic                         bs_we,
   output logic [AW-1:0]                bs_addr,
   output logic [31:0]                  bs_wdata,
   input  logic                         bs_ready,
   output logic [$clog2(BUF_DEPTH):0]   wb_level,
   output logic                         wb_full,
   output logic                         wb_empty,
   output logic                         wb_overflow,
   output logic                         misalign
`ifdef WBUF_STATS_EN
   ,
   output logic [31:0]                  wr_count,
   output logic [31:0]                  drain_count
`endif
);

   localparam int unsigned PW = $clog2(BUF_DEPTH);

   logic [AW-1:0]        addr_q [BUF_DEPTH];
   logic [31:0]          data_q [BUF_DEPTH];
   logic [BUF_DEPTH-1:0] valid_q;
   logic [PW-1:0]        head_q;
   logic [PW-1:0]        tail_q;
   logic [PW:0]          level_q;
   logic [AW-1:0]        raddr;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic                 fwd_hit;
   logic [31:0]          fwd_data;
   logic [PW-1:0]        fwd_idx;

   assign raddr = ALUResult[AW+1:2];
   assign full  = (level_q == (PW+1)'(BUF_DEPTH));
   assign pop   = (level_q != '0) && bs_ready;
   // A pop frees the head slot at the same edge, so a full buffer still accepts a store.
   assign push  = MemWrite && (!full || pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q      <= '0;
         tail_q      <= '0;
         level_q     <= '0;
         valid_q     <= '0;
         wb_overflow <= 1'b0;
      end else begin
         if (pop) begin
            head_q          <= head_q + PW'(1);
            valid_q[head_q] <= 1'b0;
         end
         if (push) begin
            tail_q          <= tail_q + PW'(1);
            valid_q[tail_q] <= 1'b1;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + (PW+1)'(1);
            2'b01:   level_q <= level_q - (PW+1)'(1);
            default: level_q <= level_q;
         endcase
         if (MemWrite && full && !pop) begin
            wb_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= raddr;
         data_q[tail_q] <= WriteData;
      end
   end

   // Scan oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head_q;
      for (int unsigned k = 0; k < BUF_DEPTH; k++) begin
         fwd_idx = head_q + PW'(k);
         if (valid_q[fwd_idx] && (addr_q[fwd_idx] == raddr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx];
         end
      end
   end

   assign ReadData = fwd_hit ? fwd_data : bs_rdata;
   assign bs_raddr = raddr;
   assign bs_we    = (level_q != '0);
   assign bs_addr  = addr_q[head_q];
   assign bs_wdata = data_q[head_q];
   assign wb_level = level_q;
   assign wb_full  = full;
   assign wb_empty = (level_q == '0);
   assign misalign = MemWrite && (ALUResult[1:0] != 2'b00);

`ifdef WBUF_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_count    <= '0;
         drain_count <= '0;
      end else begin
         if (push) wr_count    <= wr_count + 32'd1;
         if (pop)  drain_count <= drain_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_wbuf_responder.sv
// Directed self-checking bench for dmem_wbuf_responder (default parameters).
module tb_dmem_wbuf_responder;

   logic        clk;
   logic        reset;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic [29:0] bs_raddr;
   logic [31:0] bs_rdata;
   logic        bs_we;
   logic [29:0] bs_addr;
   logic [31:0] bs_wdata;
   logic        bs_ready;
   logic [2:0]  wb_level;
   logic        wb_full;
   logic        wb_empty;
   logic        wb_overflow;
   logic        misalign;
`ifdef WBUF_STATS_EN
   logic [31:0] wr_count;
   logic [31:0] drain_count;
`endif

   int checks   = 0;
   int failures = 0;

   logic [29:0] log_a [$];
   logic [31:0] log_d [$];

   dmem_wbuf_responder #(.BUF_DEPTH(4), .AW(30)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
      .WriteData(WriteData), .ReadData(ReadData), .bs_raddr(bs_raddr),
      .bs_rdata(bs_rdata), .bs_we(bs_we), .bs_addr(bs_addr), .bs_wdata(bs_wdata),
      .bs_ready(bs_ready), .wb_level(wb_level), .wb_full(wb_full),
      .wb_empty(wb_empty), .wb_overflow(wb_overflow), .misalign(misalign)
`ifdef WBUF_STATS_EN
      , .wr_count(wr_count), .drain_count(drain_count)
`endif
   );

   // Backing store read pattern: a fixed function of the word address.
   assign bs_rdata = {2'b10, bs_raddr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!reset && bs_we && bs_ready) begin
         log_a.push_back(bs_addr);
         log_d.push_back(bs_wdata);
      end
   end

   function automatic logic [31:0] bsv(input logic [31:0] a);
      return {2'b10, a[31:2]};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      MemWrite = 1'b1; ALUResult = a; WriteData = d;
      tick();
      MemWrite = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; MemWrite = 1'b1; ALUResult = 32'h300; WriteData = 32'h55; bs_ready = 1'b0;
      tick(); tick();
      checks++; if (wb_level !== 3'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", wb_level); end
      checks++; if (bs_we !== 1'b0) begin failures++; $display("FAIL rst_bs_we got=%b exp=0", bs_we); end
      checks++; if (wb_overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", wb_overflow); end
      checks++; if (wb_empty !== 1'b1 || wb_full !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=10", wb_empty, wb_full); end
      ALUResult = 32'h301; #1;
      checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL misalign_hi got=%b exp=1", misalign); end
      MemWrite = 1'b0; #1;
      checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL misalign_lo got=%b exp=0", misalign); end
      reset = 1'b0; ALUResult = 32'h300;
      tick();
      checks++; if (wb_level !== 3'd0) begin failures++; $display("FAIL rst_nopush_level got=%0d exp=0", wb_level); end
      #1;
      checks++; if (ReadData !== bsv(32'h300)) begin failures++; $display("FAIL rst_nofwd got=%h exp=%h", ReadData, bsv(32'h300)); end
   endtask

   task automatic test_store_load();
      int base;
      base = log_a.size();
      bs_ready = 1'b0;
      store(32'h100, 32'hDEADBEEF);
      ALUResult = 32'h100; #1;
      checks++; if (ReadData !== 32'hDEADBEEF) begin failures++; $display("FAIL sl_fwd got=%h exp=deadbeef", ReadData); end
      checks++; if (bs_we !== 1'b1 || bs_addr !== 30'h40 || bs_wdata !== 32'hDEADBEEF) begin
         failures++; $display("FAIL sl_head got=%b/%h/%h exp=1/40/deadbeef", bs_we, bs_addr, bs_wdata); end
      MemWrite = 1'b1; ALUResult = 32'h104; WriteData = 32'h12345678; #1;
      checks++; if (ReadData !== bsv(32'h104)) begin failures++; $display("FAIL sl_same_cycle got=%h exp=%h", ReadData, bsv(32'h104)); end
      tick();
      MemWrite = 1'b0; #1;
      checks++; if (ReadData !== 32'h12345678) begin failures++; $display("FAIL sl_next_cycle got=%h exp=12345678", ReadData); end
      MemWrite = 1'b1; ALUResult = 32'h10A; WriteData = 32'h0BADF00D; #1;
      checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL sl_misalign got=%b exp=1", misalign); end
      tick();
      MemWrite = 1'b0; ALUResult = 32'h108; #1;
      checks++; if (ReadData !== 32'h0BADF00D || wb_level !== 3'd3) begin
         failures++; $display("FAIL sl_misaligned_store got=%h/%0d exp=0badf00d/3", ReadData, wb_level); end
      bs_ready = 1'b1;
      tick(); tick(); tick();
      bs_ready = 1'b0;
      checks++; if (wb_empty !== 1'b1) begin failures++; $display("FAIL sl_drained got=%b exp=1", wb_empty); end
      checks++; if (log_a.size() !== base + 3) begin failures++; $display("FAIL sl_drain_count got=%0d exp=%0d", log_a.size() - base, 3); end
      else begin
         checks++; if (log_a[base] !== 30'h40 || log_d[base] !== 32'hDEADBEEF ||
                       log_a[base+1] !== 30'h41 || log_d[base+1] !== 32'h12345678 ||
                       log_a[base+2] !== 30'h42 || log_d[base+2] !== 32'h0BADF00D) begin
            failures++; $display("FAIL sl_drain_order got=%h:%h %h:%h %h:%h exp=40:deadbeef 41:12345678 42:0badf00d",
               log_a[base], log_d[base], log_a[base+1], log_d[base+1], log_a[base+2], log_d[base+2]); end
      end
      ALUResult = 32'h100; #1;
      checks++; if (ReadData !== bsv(32'h100)) begin failures++; $display("FAIL sl_after_drain got=%h exp=%h", ReadData, bsv(32'h100)); end
   endtask

   task automatic test_youngest();
      int base;
      base = log_a.size();
      bs_ready = 1'b0;
      store(32'h200, 32'h11);
      store(32'h200, 32'h22);
      ALUResult = 32'h200; #1;
      checks++; if (ReadData !== 32'h22 || wb_level !== 3'd2) begin failures++; $display("FAIL yg_fwd got=%h/%0d exp=22/2", ReadData, wb_level); end
      bs_ready = 1'b1;
      tick(); #1;
      checks++; if (log_d.size() !== base + 1 || log_d[log_d.size()-1] !== 32'h11 || log_a[log_a.size()-1] !== 30'h80) begin
         failures++; $display("FAIL yg_first_drain got=%0d entries exp=1 of 80:11", log_d.size() - base); end
      checks++; if (ReadData !== 32'h22) begin failures++; $display("FAIL yg_still_fwd got=%h exp=22", ReadData); end
      tick(); #1;
      checks++; if (log_d.size() !== base + 2 || log_d[log_d.size()-1] !== 32'h22) begin
         failures++; $display("FAIL yg_second_drain got=%0d entries exp=2 ending 22", log_d.size() - base); end
      checks++; if (ReadData !== bsv(32'h200) || wb_empty !== 1'b1) begin
         failures++; $display("FAIL yg_no_fwd got=%h/%b exp=%h/1", ReadData, wb_empty, bsv(32'h200)); end
      bs_ready = 1'b0;
   endtask

   task automatic test_fill_overflow();
      int base;
      logic [29:0] ea [5];
      logic [31:0] ed [5];
      ea = '{30'h100, 30'h101, 30'h102, 30'h103, 30'h105};
      ed = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA5};
      base = log_a.size();
      bs_ready = 1'b0;
      for (int i = 0; i < 4; i++) store(32'h400 + 32'(4*i), 32'hA0 + 32'(i));
      checks++; if (wb_full !== 1'b1 || wb_level !== 3'd4 || wb_overflow !== 1'b0) begin
         failures++; $display("FAIL fo_full got=%b/%0d/%b exp=1/4/0", wb_full, wb_level, wb_overflow); end
      store(32'h410, 32'hA4);
      checks++; if (wb_overflow !== 1'b1 || wb_level !== 3'd4) begin
         failures++; $display("FAIL fo_overflow got=%b/%0d exp=1/4", wb_overflow, wb_level); end
      ALUResult = 32'h410; #1;
      checks++; if (ReadData !== bsv(32'h410)) begin failures++; $display("FAIL fo_dropped got=%h exp=%h", ReadData, bsv(32'h410)); end
      bs_ready = 1'b1;
      store(32'h414, 32'hA5);
      checks++; if (wb_level !== 3'd4 || wb_full !== 1'b1 || log_a.size() !== base + 1) begin
         failures++; $display("FAIL fo_push_pop got=%0d/%b/%0d exp=4/1/1", wb_level, wb_full, log_a.size() - base); end
      ALUResult = 32'h414; #1;
      checks++; if (ReadData !== 32'hA5) begin failures++; $display("FAIL fo_reused_slot got=%h exp=a5", ReadData); end
      ALUResult = 32'h400; #1;
      checks++; if (ReadData !== bsv(32'h400)) begin failures++; $display("FAIL fo_popped got=%h exp=%h", ReadData, bsv(32'h400)); end
      tick(); tick(); tick(); tick();
      bs_ready = 1'b0;
      checks++; if (wb_empty !== 1'b1 || wb_overflow !== 1'b1) begin
         failures++; $display("FAIL fo_end got=%b/%b exp=1/1", wb_empty, wb_overflow); end
      checks++; if (log_a.size() !== base + 5) begin failures++; $display("FAIL fo_drain_count got=%0d exp=5", log_a.size() - base); end
      else begin
         for (int i = 0; i < 5; i++) begin
            checks++; if (log_a[base+i] !== ea[i] || log_d[base+i] !== ed[i]) begin
               failures++; $display("FAIL fo_order[%0d] got=%h:%h exp=%h:%h", i, log_a[base+i], log_d[base+i], ea[i], ed[i]); end
         end
      end
   endtask

   task automatic test_wrap();
      int base;
      int n;
      reset = 1'b1; tick(); reset = 1'b0;
      checks++; if (wb_overflow !== 1'b0) begin failures++; $display("FAIL wr_ovf_cleared got=%b exp=0", wb_overflow); end
      base = log_a.size();
      n = 0;
      for (int c = 0; c < 15; c++) begin
         bs_ready = c[0];
         if (c % 3 != 2) begin
            MemWrite = 1'b1; ALUResult = 32'h800 + 32'(4*n); WriteData = 32'hC0DE0000 + 32'(n);
            n++;
         end else begin
            MemWrite = 1'b0;
         end
         tick();
      end
      MemWrite = 1'b0; bs_ready = 1'b1;
      for (int i = 0; i < 8 && !wb_empty; i++) tick();
      bs_ready = 1'b0;
      checks++; if (wb_empty !== 1'b1 || wb_overflow !== 1'b0) begin
         failures++; $display("FAIL wr_end got=%b/%b exp=1/0", wb_empty, wb_overflow); end
      checks++; if (log_a.size() !== base + 10) begin failures++; $display("FAIL wr_drain_count got=%0d exp=10", log_a.size() - base); end
      else begin
         for (int i = 0; i < 10; i++) begin
            checks++; if (log_a[base+i] !== 30'h200 + 30'(i) || log_d[base+i] !== 32'hC0DE0000 + 32'(i)) begin
               failures++; $display("FAIL wr_order[%0d] got=%h:%h exp=%h:%h", i, log_a[base+i], log_d[base+i],
                  30'h200 + 30'(i), 32'hC0DE0000 + 32'(i)); end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      int base;
      bs_ready = 1'b0;
      store(32'hC00, 32'hD0);
      store(32'hC04, 32'hD1);
      store(32'hC08, 32'hD2);
      ALUResult = 32'hC04; #1;
      checks++; if (bs_we !== 1'b1 || wb_level !== 3'd3 || ReadData !== 32'hD1) begin
         failures++; $display("FAIL rm_pending got=%b/%0d/%h exp=1/3/d1", bs_we, wb_level, ReadData); end
      base = log_a.size();
      reset = 1'b1; tick(); reset = 1'b0; #1;
      checks++; if (bs_we !== 1'b0 || wb_empty !== 1'b1) begin failures++; $display("FAIL rm_cleared got=%b/%b exp=0/1", bs_we, wb_empty); end
      checks++; if (ReadData !== bsv(32'hC04)) begin failures++; $display("FAIL rm_no_fwd got=%h exp=%h", ReadData, bsv(32'hC04)); end
      bs_ready = 1'b1;
      tick(); tick();
      bs_ready = 1'b0;
      checks++; if (log_a.size() !== base || bs_we !== 1'b0) begin
         failures++; $display("FAIL rm_no_writes got=%0d/%b exp=0/0", log_a.size() - base, bs_we); end
   endtask

   initial begin
      reset = 1'b1; MemWrite = 1'b0; ALUResult = '0; WriteData = '0; bs_ready = 1'b0;
      test_reset();
      test_store_load();
      test_youngest();
      test_fill_overflow();
      test_wrap();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_wbuf_responder.md
Name: dmem_wbuf_responder

Overview:
- Memory-side responder for the single-cycle CPU data port. Services MemWrite/ALUResult/WriteData and returns ReadData.
- Stores are posted into a small in-order write buffer. The buffer drains one entry at a time to a backing-store port that has a ready handshake.
- Loads return data in the same cycle, combinationally. The youngest matching buffered store is forwarded ahead of backing-store data.

Parameters:
- BUF_DEPTH, 4, number of write-buffer entries; power of two, range 2..16
- AW, 30, word-address width toward the backing store; taken from ALUResult[AW+1:2]

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- MemWrite  input  1  CPU store strobe, sampled at the rising edge
- ALUResult  input  32  CPU byte address; bits [1:0] ignored for indexing
- WriteData  input  32  CPU store data
- ReadData  output  32  load data, combinational from ALUResult
- bs_raddr  output  AW  backing-store read address, equal to ALUResult[AW+1:2]
- bs_rdata  input  32  backing-store read data, combinational from bs_raddr
- bs_we  output  1  write request to the backing store; high whenever the buffer is non-empty
- bs_addr  output  AW  word address of the buffer head entry
- bs_wdata  output  32  data of the buffer head entry
- bs_ready  input  1  backing store accepts the head entry at this edge when bs_we=1
- wb_level  output  $clog2(BUF_DEPTH)+1  current occupancy
- wb_full  output  1  wb_level==BUF_DEPTH
- wb_empty  output  1  wb_level==0
- wb_overflow  output  1  sticky flag: a store was dropped
- misalign  output  1  combinational: MemWrite & (ALUResult[1:0]!=0)

Behaviour:
- Reset (synchronous, active-high):
  - head, tail and level are cleared to 0; wb_overflow is cleared to 0.
  - After the edge: bs_we=0, wb_empty=1, wb_full=0.
  - Buffer entries are discarded, including any drain that was in progress; the backing store receives no further writes for those entries.
  - Entry contents after reset are don't-care; they must never be forwarded because their valid bits are cleared.
- Push: at an edge with MemWrite=1 and space available, {ALUResult[AW+1:2], WriteData} is written at tail; tail and level increment.
- Pop: at an edge with bs_we=1 and bs_ready=1, head advances and level decrements.
- Push and pop at the same edge: both occur and level is unchanged. This holds when full, because the popped slot is reused, so no overflow is raised.
- Overflow: full, MemWrite=1 and no pop at that edge. The store is dropped, wb_overflow is set to 1, and pointers are unchanged. The flag stays set until reset.
- Pointers wrap modulo BUF_DEPTH.
- Store ordering to the backing store is strict FIFO. Stores to the same address are not coalesced.
- ReadData:
  - Scan all valid entries; if any entry's address equals ALUResult[AW+1:2], return the data of the youngest such entry.
  - Otherwise return bs_rdata.
  - A store presented in the same cycle is not visible: the read sees the state before that store.
  - An entry popped at an edge is no longer forwarded after that edge; the backing store must already hold its data.
- Misaligned stores are still accepted, using the word index. misalign is informational only.
- bs_addr and bs_wdata are held stable while bs_we=1 and bs_ready=0.
- Latency:
  - Load: 0 cycles.
  - Store: visible through forwarding from the next cycle; reaches the backing store at the earliest 1 edge after push.

Optional Feature:
- Macro: WBUF_STATS_EN.
- When defined, two extra output ports are added:
  - wr_count (32): counts accepted pushes.
  - drain_count (32): counts pops.
  - Both counters are cleared by reset and wrap modulo 2^32; dropped stores are not counted.
- When undefined, these ports and counters are absent and all other behaviour is identical.

Test Plan:
- Reset check: assert reset for 2 cycles with MemWrite=1 -> wb_level=0, bs_we=0, wb_overflow=0, and no push occurs.
- Store then load:
  - Stimulus: bs_ready=0; store 0xDEADBEEF to 0x100; next cycle ALUResult=0x100.
  - Expected: ReadData=0xDEADBEEF, bs_we=1, bs_addr=0x40.
  - With ALUResult=0x104, ReadData=bs_rdata.
- Youngest-match forwarding and drain order:
  - Stimulus: stores 0x11 then 0x22 to 0x200; bs_ready=0.
  - Expected: ReadData=0x22.
  - Then raise bs_ready: the backing store receives 0x11 then 0x22, in order, on consecutive edges.
- Fill and overflow:
  - Stimulus: bs_ready=0; 4 stores -> wb_full=1.
  - A 5th store -> dropped, wb_overflow=1, wb_level=4.
  - A 6th store with bs_ready=1 -> accepted, wb_level stays 4, no new overflow.
- Wrap-around: 10 stores with bs_ready toggling every cycle -> every address/data pair drains exactly once, in order, and wb_empty=1 at the end.
- Reset mid-drain: 3 entries pending, bs_ready=0, assert reset -> bs_we=0 next cycle; a read of a previously buffered address returns bs_rdata.
